// File: rtl/feature_pool_buffer_if.sv
// Stream-side bundle of the feature pool buffer: activation input, pooled
// ready/valid output and status flags.
interface feature_pool_buffer_if #(
  parameter int IN_W  = 22,
  parameter int OUT_W = 22
);
  logic             frame_start;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             frame_done;
  logic             overflow_err;

  modport master (
    output frame_start, in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, frame_done, overflow_err
  );

  modport slave (
    input  frame_start, in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, frame_done, overflow_err
  );
endinterface

// File: rtl/feature_pool_buffer.sv
// Ping-pong feature-map buffer: one bank captures a saturated activation frame
// while the other is 2x2/stride-2 max pooled onto a ready/valid output.
module feature_pool_buffer #(
  parameter int IMG_W   = 30,
  parameter int IMG_H   = 30,
  parameter int IN_W    = 22,
  parameter int STORE_W = 16,
  parameter int OUT_W   = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  feature_pool_buffer_if.slave  bus
);
  localparam int N     = IMG_W * IMG_H;
  localparam int PW    = IMG_W / 2;
  localparam int PH    = IMG_H / 2;
  localparam int AW    = $clog2(N);
  localparam int IDX_W = $clog2(2 * N);
  localparam int PC_W  = $clog2(PW + 1);
  localparam int PR_W  = $clog2(PH + 1);

  localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-STORE_W+1){1'b0}}, {(STORE_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-STORE_W+1){1'b1}}, {(STORE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  logic signed [STORE_W-1:0] mem [2*N];
  logic signed [STORE_W-1:0] sat_data, rd_data, run_max, pool_max;
  logic [AW-1:0]    waddr, wr_addr;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             wbank, rbank, wr_en, last_pos;
  logic [1:0]       full, full_set, full_clr;
  state_t           state;
  logic [2:0]       fcnt;
  logic [PR_W-1:0]  pr;
  logic [PC_W-1:0]  pc;
  int               rd_row, rd_col;

  // NOTE: every always_comb output gets a value on all paths, so no latch is inferred.
  always_comb begin
    sat_data = bus.in_data[STORE_W-1:0];
    if ($signed(bus.in_data) > SAT_MAX)      sat_data = {1'b0, {(STORE_W-1){1'b1}}};
    else if ($signed(bus.in_data) < SAT_MIN) sat_data = {1'b1, {(STORE_W-1){1'b0}}};
  end

  assign wr_addr  = bus.frame_start ? '0 : waddr;
  assign wr_en    = bus.in_valid && !full[wbank];
  assign wr_idx   = IDX_W'((wbank ? N : 0) + int'(wr_addr));
  assign last_pos = (pr == PR_W'(PH - 1)) && (pc == PC_W'(PW - 1));
  assign pool_max = (rd_data > run_max) ? rd_data : run_max;
  assign full_set = (wr_en && wr_addr == AW'(N - 1)) ? (2'b01 << wbank) : 2'b00;
  assign full_clr = (state == EMIT && bus.out_ready && last_pos) ? (2'b01 << rbank) : 2'b00;

  // FETCH cycle k (0..3) addresses window element k in raster order.
  always_comb begin
    rd_row = 2 * int'(pr) + int'(fcnt[1]);
    rd_col = 2 * int'(pc) + int'(fcnt[0]);
    rd_idx = IDX_W'((rbank ? N : 0) + rd_row * IMG_W + rd_col);
  end

  // NOTE: storage has no reset so it maps onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= sat_data;
    rd_data <= mem[rd_idx];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr            <= '0;
      wbank            <= 1'b0;
      full             <= 2'b00;
      bus.overflow_err <= 1'b0;
    end else begin
      full <= (full | full_set) & ~full_clr;
      if (bus.in_valid && full[wbank]) bus.overflow_err <= 1'b1;
      if (wr_en) begin
        if (wr_addr == AW'(N - 1)) begin
          waddr <= '0;
          wbank <= ~wbank;
        end else begin
          waddr <= wr_addr + 1'b1;
        end
      end else if (bus.frame_start) begin
        waddr <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rbank          <= 1'b0;
      fcnt           <= '0;
      pr             <= '0;
      pc             <= '0;
      run_max        <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            state <= FETCH;
            fcnt  <= '0;
            pr    <= '0;
            pc    <= '0;
          end
        end
        FETCH: begin
          fcnt <= fcnt + 3'd1;
          case (fcnt)
            3'd1:       run_max <= rd_data;
            3'd2, 3'd3: run_max <= pool_max;
            3'd4: begin
              bus.out_data  <= OUT_W'(pool_max);
              bus.out_valid <= 1'b1;
              bus.out_last  <= last_pos;
              state         <= EMIT;
            end
            default: ;
          endcase
        end
        EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            fcnt          <= '0;
            if (last_pos) begin
              rbank          <= ~rbank;
              bus.frame_done <= 1'b1;
              state          <= IDLE;
            end else begin
              state <= FETCH;
              if (pc == PC_W'(PW - 1)) begin
                pc <= '0;
                pr <= pr + 1'b1;
              end else begin
                pc <= pc + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_feature_pool_buffer.sv
// Self-checking bench for feature_pool_buffer on a 4x4 map: a frame-level
// model predicts every pooled result, flag and pulse; literals pin the model.
module tb_feature_pool_buffer;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int IN_W    = 22;
  localparam int STORE_W = 16;
  localparam int OUT_W   = 22;
  localparam int N       = IMG_W * IMG_H;
  localparam int SMAX    = (1 << (STORE_W - 1)) - 1;
  localparam int SMIN    = -(1 << (STORE_W - 1));

  typedef struct {
    int data;
    bit last;
  } res_t;

  logic clk = 1'b0;
  logic rst;

  feature_pool_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  feature_pool_buffer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .IN_W(IN_W), .STORE_W(STORE_W), .OUT_W(OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  res_t exp_q[$];
  int   acc_log[$];
  int   cur[N];
  int   wptr, stored, fd_cnt;
  bit   exp_ovf, exp_fd;
  int   exp8[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sat(int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // A completed frame becomes its list of window maxima, in raster order.
  function automatic void push_frame();
    for (int r = 0; r < IMG_H / 2; r++) begin
      for (int c = 0; c < IMG_W / 2; c++) begin
        int m;
        m = cur[2 * r * IMG_W + 2 * c];
        for (int k = 1; k < 4; k++) begin
          int v;
          v = cur[(2 * r + k / 2) * IMG_W + 2 * c + k % 2];
          if (v > m) m = v;
        end
        exp_q.push_back('{data: m, last: (r == IMG_H / 2 - 1) && (c == IMG_W / 2 - 1)});
      end
    end
  endfunction

  // Frame-level model: "stored" counts complete frames not yet fully emitted.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      stored  = 0;
      wptr    = 0;
      exp_ovf = 1'b0;
      exp_fd  = 1'b0;
    end else begin
      exp_fd = 1'b0;
      if (bus.frame_start) wptr = 0;
      if (bus.in_valid) begin
        if (stored == 2) begin
          exp_ovf = 1'b1;
        end else begin
          cur[wptr] = sat(int'($signed(bus.in_data)));
          wptr++;
          if (wptr == N) begin
            wptr = 0;
            stored++;
            push_frame();
          end
        end
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
        res_t r;
        r = exp_q.pop_front();
        acc_log.push_back(r.data);
        if (r.last) begin
          stored--;
          exp_fd = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("frame_done", bus.frame_done, exp_fd);
      check("overflow_err", bus.overflow_err, exp_ovf);
      if (bus.frame_done) fd_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", bus.out_valid, 0);
        end else begin
          check("out_data", $signed(bus.out_data), exp_q[0].data);
          check("out_last", bus.out_last, exp_q[0].last);
        end
      end
    end
  end

  task automatic send(input int v, input bit fs);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.frame_start = fs;
    bus.in_data     = IN_W'(v);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.out_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_log(input string name, input int base, input int n);
    check({name, "_count"}, acc_log.size() - base, n);
    for (int k = 0; k < n; k++) begin
      if (base + k < acc_log.size()) check($sformatf("%s[%0d]", name, k), acc_log[base + k], exp8[k]);
    end
  endtask

  initial begin
    int base, lat, fd0;
    int fr[N];
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.out_ready   = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overflow_err", bus.overflow_err, 0);
    @(negedge clk) rst = 1'b1;

    // Ramp 0..15 with first-result latency measured from the final write.
    base = acc_log.size();
    for (int i = 0; i < N; i++) send(i, 1'b0);
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t1_latency", lat, 6);
    wait_drain("t1_drain");
    check("t1_frame_done_pulses", fd_cnt, 1);
    exp8 = '{5, 7, 13, 15, 0, 0, 0, 0};
    check_log("t1_result", base, 4);

    // Saturation on both rails, including an all-negative window.
    base = acc_log.size();
    for (int i = 0; i < N; i++) fr[i] = 0;
    fr[0] = 40000;
    fr[2] = -40000; fr[3] = -5; fr[6] = -5; fr[7] = -5;
    fr[8] = -40000; fr[9] = -40000; fr[12] = -40000; fr[13] = -40000;
    for (int i = 0; i < N; i++) send(fr[i], 1'b0);
    idle();
    wait_drain("t2_drain");
    exp8 = '{32767, -5, -32768, 0, 0, 0, 0, 0};
    check_log("t2_result", base, 4);

    // Backpressure: first result must hold for 10 stalled cycles.
    base = acc_log.size();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(100 - 7 * i, 1'b0);
    idle();
    wait_valid("t3_valid");
    repeat (10) @(negedge clk);
    check("t3_hold_valid", bus.out_valid, 1);
    check("t3_hold_data", $signed(bus.out_data), 100);
    check("t3_hold_last", bus.out_last, 0);
    bus.out_ready = 1'b1;
    wait_drain("t3_drain");
    exp8 = '{100, 86, 44, 30, 0, 0, 0, 0};
    check_log("t3_result", base, 4);

    // Three back-to-back frames while stalled: the third is dropped.
    base = acc_log.size();
    fd0  = fd_cnt;
    bus.out_ready = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) send((f == 0) ? i : (f == 1) ? 100 + i : -50 - i, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    check("t4_overflow_err", bus.overflow_err, 1);
    bus.out_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_frame_done_pulses", fd_cnt - fd0, 2);
    exp8 = '{5, 7, 13, 15, 105, 107, 113, 115};
    check_log("t4_result", base, 8);

    // frame_start abandons a 7-sample partial frame.
    base = acc_log.size();
    for (int i = 0; i < 7; i++) send(999, 1'b0);
    send(0, 1'b1);
    for (int i = 1; i < N; i++) send(2 * i, 1'b0);
    idle();
    wait_drain("t5_drain");
    exp8 = '{10, 14, 26, 30, 0, 0, 0, 0};
    check_log("t5_result", base, 4);

    // Reset while a result is being offered, then a fresh frame.
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(i, 1'b0);
    idle();
    wait_valid("t6_valid");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_data", bus.out_data, 0);
    check("t6_rst_out_last", bus.out_last, 0);
    check("t6_rst_frame_done", bus.frame_done, 0);
    check("t6_rst_overflow_err", bus.overflow_err, 0);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    bus.out_ready = 1'b1;
    base = acc_log.size();
    for (int i = 0; i < N; i++) send(15 - i, 1'b0);
    idle();
    wait_drain("t6_drain");
    exp8 = '{15, 13, 7, 5, 0, 0, 0, 0};
    check_log("t6_result", base, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/feature_pool_buffer.md
# feature_pool_buffer

Parametrised ping-pong feature-map buffer with integrated 2x2 stride-2 max pooling and ready/valid output. It sits between the activation stage and the next layer. It captures a signed activation stream into one of two on-chip banks, saturating each sample to the storage width. Meanwhile it pools the other, already-complete bank, so frame capture and pooling overlap. Downstream backpressure is honoured without losing data.

## Interface
- IMG_W, 30, input feature-map width in pixels; must be even, ≥2
- IMG_H, 30, input feature-map height in pixels; must be even, ≥2
- IN_W, 22, signed input sample width
- STORE_W, 16, signed stored sample width (≤ IN_W)
- OUT_W, 22, signed output width (≥ STORE_W)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  restarts capture of the current write bank at address 0
- in_valid  in  1  in_data valid this cycle; there is no input ready
- in_data  in  IN_W  signed activation sample, raster order
- out_ready  in  1  downstream accepts out_data
- out_valid  out  1  pooled result available
- out_data  out  OUT_W  signed pooled maximum, sign-extended from STORE_W
- out_last  out  1  qualifies the final pooled result of a frame
- frame_done  out  1  one-cycle pulse after the last result of a frame is accepted
- overflow_err  out  1  sticky; a sample was dropped because both banks were full

## Operation
- Memory: two banks of N = IMG_W*IMG_H words × STORE_W, inferred as block RAM with synchronous read. Contents are not reset.
- Per-bank flag full[b] is set by the writer and cleared by the reader. Pointers wbank and rbank both reset to 0.
- Write side, per in_valid:
  - If full[wbank]=0: store sat(in_data) at waddr, then waddr++.
  - At waddr=N-1: set full[wbank], toggle wbank, waddr←0.
  - If full[wbank]=1: drop the sample and set overflow_err. overflow_err clears only on reset.
- sat(): values > 2^(STORE_W-1)-1 clamp to max; values < -2^(STORE_W-1) clamp to min; otherwise take the low STORE_W bits.
- frame_start: waddr←0, discarding any partial frame; full flags are unaffected. If in_valid is also high in that cycle, the sample is written at address 0 and waddr←1.
- Read FSM states: IDLE, FETCH, EMIT.
  - IDLE→FETCH when full[rbank]=1. Pooled coordinates (pr,pc) start at (0,0).
  - FETCH lasts 5 cycles. Cycles 0-3 issue reads at (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1), where address = row*IMG_W+col. Cycles 1-4 capture the returned data; the first capture loads the running max, later captures update it with a signed compare. Then go to EMIT.
  - EMIT holds out_valid=1 with out_data and out_last stable until out_ready=1. On acceptance:
    - If more pooled results remain: advance pc, and pr on wrap at IMG_W/2; go to FETCH.
    - Otherwise: clear full[rbank], toggle rbank, pulse frame_done, go to IDLE.
- out_last=1 only on the EMIT of (IMG_H/2-1, IMG_W/2-1).
- A frame yields exactly (IMG_W/2)*(IMG_H/2) results. Banks are read in fill order.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, frame_done=0, overflow_err=0, FSM=IDLE, waddr=0, full=00.
- Reset asserted mid-operation aborts everything immediately: stored frames are lost, and out_valid drops asynchronously.
- After the write that sets full, FETCH is entered on the next cycle. out_valid is first asserted 6 cycles after that final write.
- Throughput is 1 result per 6 cycles with out_ready held high.
- frame_done asserts the cycle after the out_last handshake. The bank flag is freed in the same edge, so a sample in that next cycle targeting that bank is accepted.
- The writer and reader never touch the same bank; setting and clearing flags in the same cycle on different banks is legal.
- A third frame arriving while both banks are full is dropped sample by sample until a bank frees; capture resumes at the current waddr.

## Test plan
- IMG_W=IMG_H=4, STORE_W=16: stream 0..15 → out_data 5, 7, 13, 15; out_last on the 4th result; frame_done pulses once.
- Saturation: 4×4 frame containing 40000 and -40000, all other samples 0 → stored values 32767 and -32768. A 2x2 window containing only -40000 and -5 → -5; an all-negative window holding -40000 → -32768 when it is the max.
- Backpressure: hold out_ready=0 for 10 cycles while out_valid=1 → out_data and out_last stay stable; no results lost or duplicated.
- Overlap: three back-to-back 4×4 frames with out_ready=0 → frames 1 and 2 are stored and frame 3 is dropped with overflow_err=1. Release out_ready → 8 correct results in order.
- frame_start after 7 samples, then 16 new samples → results computed from the new samples only.
- Assert rst during EMIT → all outputs return to reset values. A fresh frame afterwards pools correctly from bank 0.
